// File: rtl/fetch_stage_if.sv
// fetch_stage_if
//   Bundles the fetch stage's control inputs, program-load port and decode-side
//   outputs into a single interface.
//   master : the controller/decode side. It drives stall, redirect and program
//            load, and it receives the fetched instruction stream.
//   slave  : the fetch stage itself.
//   Signals:
//     stall            hold fetch PC and output registers
//     redirect_en      take a redirect this cycle (wins over stall)
//     redirect_base_pc PC of the redirecting instruction
//     redirect_offset  signed byte offset added to redirect_base_pc
//     imem_we/waddr/wdata  program-load write port (word addressed)
//     instruction      instruction to decode (NOP when instr_valid = 0)
//     pc               byte PC of instruction
//     instr_valid      instruction/pc are a real fetch
//     fetch_count      number of valid instructions handed to decode
interface fetch_stage_if #(
   parameter int IMEM_WORDS = 1024
);
   localparam int AW = $clog2(IMEM_WORDS);

   logic                stall;
   logic                redirect_en;
   logic [31:0]         redirect_base_pc;
   logic signed [31:0]  redirect_offset;
   logic                imem_we;
   logic [AW-1:0]       imem_waddr;
   logic [31:0]         imem_wdata;
   logic [31:0]         instruction;
   logic [31:0]         pc;
   logic                instr_valid;
   logic [31:0]         fetch_count;

   modport master (
      output stall, redirect_en, redirect_base_pc, redirect_offset,
      output imem_we, imem_waddr, imem_wdata,
      input  instruction, pc, instr_valid, fetch_count
   );

   modport slave (
      input  stall, redirect_en, redirect_base_pc, redirect_offset,
      input  imem_we, imem_waddr, imem_wdata,
      output instruction, pc, instr_valid, fetch_count
   );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage feeding decode. Owns the fetch PC and a
//   synchronous-read, read-first instruction memory. Delivers one instruction
//   and its PC per cycle; a redirect squashes the in-flight fetch and inserts a
//   single NOP bubble.
//   Ports:
//     clk      rising-edge clock
//     reset_n  synchronous active-low reset
//     fif      fetch_stage_if.slave (stall, redirect, program load, outputs)
module fetch_stage #(
   parameter int          IMEM_WORDS = 1024,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic          clk,
   input  logic          reset_n,
   fetch_stage_if.slave  fif
);
   localparam int AW = $clog2(IMEM_WORDS);

   logic [31:0]   mem [IMEM_WORDS];

   logic [31:0]   fetch_pc_p0;
   logic [AW-1:0] raddr_p0;
   logic          advance_p0;

   logic [31:0]   instr_p1;
   logic [31:0]   pc_p1;
   logic          vld_p1;
   logic [31:0]   fetch_count_q;

   // Redirect target: word aligned sum of base and signed offset.
   function automatic logic [31:0] redirect_target(
      input logic [31:0]        base,
      input logic signed [31:0] offset
   );
      logic [31:0] sum;
      sum = base + $unsigned(offset);
      return sum & 32'hFFFF_FFFC;
   endfunction

   // Upper PC bits are dropped, so fetch addresses wrap over the memory.
   assign raddr_p0   = fetch_pc_p0[AW+1:2];
   assign advance_p0 = !fif.stall && !fif.redirect_en;

   // Program load is accepted every cycle, reset included.
   always_ff @(posedge clk) begin
      if (fif.imem_we)
         mem[fif.imem_waddr] <= fif.imem_wdata;
   end

   // ---- stage p0 -> p1: memory read (read-first against the write above) ----
   always_ff @(posedge clk) begin
      if (advance_p0)
         instr_p1 <= mem[raddr_p0];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fetch_pc_p0   <= RESET_PC;
         pc_p1         <= 32'h0;
         vld_p1        <= 1'b0;
         fetch_count_q <= 32'h0;
      end else if (fif.redirect_en) begin
         fetch_pc_p0 <= redirect_target(fif.redirect_base_pc, fif.redirect_offset);
         pc_p1       <= 32'h0;
         vld_p1      <= 1'b0;
      end else if (!fif.stall) begin
         fetch_pc_p0   <= fetch_pc_p0 + 32'd4;
         pc_p1         <= fetch_pc_p0;
         vld_p1        <= 1'b1;
         fetch_count_q <= fetch_count_q + 32'd1;
      end
   end

   // ---- stage p1: decode-facing outputs ----
   // instr_p1 is not reset; invalid slots are masked to NOP here instead.
   assign fif.instruction = vld_p1 ? instr_p1 : NOP_INSTR;
   assign fif.pc          = pc_p1;
   assign fif.instr_valid = vld_p1;
   assign fif.fetch_count = fetch_count_q;
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the fetch PC register and a synchronous-read instruction memory.
- Delivers one instruction and its PC per cycle to decode; a program-load write port fills the memory.
- Handles pipeline stall and control-flow redirect (branch/jal/jalr), inserting a NOP bubble for each squashed fetch.

Parameters:
- IMEM_WORDS, 1024, instruction memory depth in 32-bit words (power of two).
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, encoding driven when no valid instruction is present (addi x0,x0,0).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- stall  input  1  hold fetch PC and output registers.
- redirect_en  input  1  take redirect this cycle.
- redirect_base_pc  input  32  PC of the redirecting instruction.
- redirect_offset  input  32  signed offset; target = base + offset.
- imem_we  input  1  program-load write enable.
- imem_waddr  input  $clog2(IMEM_WORDS)  word address of write.
- imem_wdata  input  32  write data.
- instruction  output  32  instruction to decode (NOP_INSTR when invalid).
- pc  output  32  byte PC of instruction.
- instr_valid  output  1  instruction/pc are a real fetch.
- fetch_count  output  32  number of valid instructions handed to decode.

Behaviour:
- Reset (reset_n=0 at an edge):
  - fetch_pc = RESET_PC; instr_valid = 0; pc = 0; instruction = NOP_INSTR; fetch_count = 0.
  - Memory contents are not cleared.
  - Reset mid-stall or mid-redirect wins over both.
- Memory:
  - Synchronous read indexed by fetch_pc[$clog2(IMEM_WORDS)+1:2]; upper PC bits are ignored, so addresses wrap modulo IMEM_WORDS*4.
  - Read-first: a same-cycle write to the read address returns the old data.
- Normal cycle (no stall, no redirect):
  - instruction_reg <= mem[fetch_pc]; pc <= fetch_pc; instr_valid <= 1; fetch_pc <= fetch_pc + 4 (32-bit wrap).
  - Latency is 1 cycle from PC to instruction.
  - The first valid instruction (PC = RESET_PC) appears on the first edge after reset_n rises.
- Stall (stall=1, redirect_en=0): fetch_pc, pc, instruction, instr_valid hold; fetch_count holds.
- Redirect (redirect_en=1, priority over stall):
  - target = (redirect_base_pc + redirect_offset) with bits [1:0] forced to 0; fetch_pc <= target.
  - instr_valid <= 0, instruction <= NOP_INSTR, pc <= 0 (one bubble).
  - The target instruction is valid on the following edge if not stalled.
  - A redirect in consecutive cycles uses the latest target.
- instruction output is combinationally NOP_INSTR whenever instr_valid = 0.
- fetch_count increments by 1 on each edge where the new instr_valid = 1 and stall = 0 and redirect_en = 0; wraps at 2^32.
- Program load (imem_we) is independent of stall/redirect and accepted every cycle, including during reset.

Test Plan:
- Load words 0..3 = 0x11, 0x22, 0x33, 0x44; release reset; no stall -> cycle 1 pc=0 instr=0x11, cycle 2 pc=4 instr=0x22, cycle 3 pc=8 instr=0x33; fetch_count=3.
- Hold stall=1 for 3 cycles after pc=4 -> pc=4, instr=0x22 held 4 cycles; fetch_count unchanged; after release, pc=8.
- redirect_en with base=0x8, offset=0xFFFF_FFFC -> next cycle instr_valid=0, instruction=0x13; following cycle pc=4, instr=0x22.
- redirect_en=1 and stall=1 together, base=0, offset=0xE -> redirect taken, target 0xC (bits[1:0] cleared), bubble, then pc=0xC, instr=0x44.
- IMEM_WORDS=1024, redirect to 0xFFC then run -> pc=0xFFC then 0x1000, which reads word 0 (0x11).
- Assert reset_n=0 during a stall and a redirect -> next edge: instr_valid=0, instruction=0x13, pc=0, fetch_count=0, fetch_pc=RESET_PC; memory still holds 0x11.
